ifetch_unit: RTL and testbench



---
 rtl/ifetch_unit.sv | 134 +++++++++++++
 tb/tb_ifetch_unit.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_unit.sv
// Instruction-fetch stage for the single-cycle MIPS core.
// Holds the PC, fetches one word per instruction over a req/ack handshake,
// presents it to the decoder for one EXEC window and then picks the next PC
// from the decoder's branch/jump controls and the ALU compare result.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        branch,
    input  logic        jump,
    input  logic        branch_taken,
    input  logic        stall,
    output logic [31:0] inst,
    output logic        inst_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        fetch_err
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        ERR   = 2'd3
    } state_t;

    // The low two address bits are never meaningful for word fetches.
    localparam logic [31:0] BOOT_PC  = {RESET_PC[31:2], 2'b00};
    // Value the wait counter holds at the start of the last permitted req cycle.
    localparam logic [7:0]  CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] ir_reg, ir_next;
    logic [7:0]  cnt_reg, cnt_next;

    logic [31:0] seq_pc;
    logic [31:0] jump_target;
    logic [31:0] branch_target;
    logic [31:0] branch_offset;
    logic [31:0] next_pc;

    // Branch offset: sign-extended 16-bit immediate scaled to bytes.
    assign branch_offset[17:0] = {ir_reg[15:0], 2'b00};
    generate
        for (genvar gi = 18; gi < 32; gi++) begin : g_sext
            assign branch_offset[gi] = ir_reg[15];
        end
    endgenerate

    assign seq_pc        = pc_reg + 32'd4;
    assign jump_target   = {seq_pc[31:28], ir_reg[25:0], 2'b00};
    assign branch_target = seq_pc + branch_offset;

    // Jump outranks branch; a branch only redirects when the ALU says taken.
    always_comb begin
        next_pc = seq_pc;
        if (jump) begin
            next_pc = jump_target;
        end else if (branch && branch_taken) begin
            next_pc = branch_target;
        end
    end

    // State, PC, instruction register and wait counter; reset is asynchronous.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= BOOT;
            pc_reg    <= BOOT_PC;
            ir_reg    <= 32'h0;
            cnt_reg   <= 8'h0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            ir_reg    <= ir_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Sequencing: boot, fetch with timeout, execute (stallable), sticky error.
    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        ir_next    = ir_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            BOOT: begin
                cnt_next   = 8'h0;
                state_next = FETCH;
            end
            FETCH: begin
                // An ack in the final permitted cycle still wins over the timeout.
                if (imem_ack) begin
                    ir_next    = imem_rdata;
                    cnt_next   = 8'h0;
                    state_next = EXEC;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next = ERR;
                end else begin
                    cnt_next = cnt_reg + 8'd1;
                end
            end
            EXEC: begin
                if (!stall) begin
                    pc_next    = next_pc;
                    state_next = FETCH;
                end
            end
            ERR: begin
                state_next = ERR;
            end
            default: begin
                state_next = BOOT;
            end
        endcase
    end

    // Outputs decode straight from the state register, so an asynchronous
    // reset drops imem_req in the same instant.
    assign imem_req   = (state_reg == FETCH);
    assign imem_addr  = pc_reg;
    assign inst_valid = (state_reg == EXEC);
    assign inst       = (state_reg == EXEC) ? ir_reg : 32'h0;
    assign pc         = pc_reg;
    assign pc_plus4   = seq_pc;
    assign fetch_err  = (state_reg == ERR);

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: plays instruction memory and decoder, predicts the
// PC sequence from the branch/jump rules and checks every transaction.
module tb_ifetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam logic [31:0] HI_PC  = 32'h4000_0010;
    localparam int          TMO    = 16;

    logic        clk;
    logic        rst_n;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        branch;
    logic        jump;
    logic        branch_taken;
    logic        stall;

    logic        imem_req,    hi_imem_req;
    logic [31:0] imem_addr,   hi_imem_addr;
    logic [31:0] inst,        hi_inst;
    logic        inst_valid,  hi_inst_valid;
    logic [31:0] pc,          hi_pc;
    logic [31:0] pc_plus4,    hi_pc_plus4;
    logic        fetch_err,   hi_fetch_err;

    int          pass_cnt  = 0;
    int          total_cnt = 0;
    int          fail_cnt  = 0;
    logic [31:0] exp_pc;

    ifetch_unit #(.RESET_PC(RST_PC), .TIMEOUT(TMO)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .branch(branch), .jump(jump), .branch_taken(branch_taken), .stall(stall),
        .inst(inst), .inst_valid(inst_valid), .pc(pc), .pc_plus4(pc_plus4),
        .fetch_err(fetch_err)
    );

    // Second copy in the upper address region, used for the jump-region case.
    ifetch_unit #(.RESET_PC(HI_PC), .TIMEOUT(TMO)) u_dut_hi (
        .clk(clk), .rst_n(rst_n),
        .imem_req(hi_imem_req), .imem_addr(hi_imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .branch(branch), .jump(jump), .branch_taken(branch_taken), .stall(stall),
        .inst(hi_inst), .inst_valid(hi_inst_valid), .pc(hi_pc), .pc_plus4(hi_pc_plus4),
        .fetch_err(hi_fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, required finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Next-PC rule in plain arithmetic: word jump inside the current 256MB
    // region, PC-relative word branch, otherwise sequential; all mod 2^32.
    function automatic logic [31:0] ref_next_pc(input logic [31:0] cur_pc,
                                                input logic [31:0] word,
                                                input logic br, input logic jmp,
                                                input logic tk);
        logic [31:0] seq;
        int          off;
        seq = cur_pc + 32'd4;
        if (jmp) return (seq & 32'hF000_0000) | ((word & 32'h03FF_FFFF) * 4);
        if (br && tk) begin
            off = int'($signed(word[15:0]));
            return seq + 32'(off * 4);
        end
        return seq;
    endfunction

    // Memory side: wait 'delay' cycles with no ack, then ack with 'word'.
    // Decoder controls are scrambled here since they must be ignored.
    task automatic do_fetch(input logic [31:0] word, input int delay);
        for (int i = 0; i < delay; i++) begin
            chkb("fetch_req", imem_req, 1'b1);
            chk("fetch_addr", imem_addr, exp_pc);
            chk("fetch_inst_zero", inst, 32'h0);
            imem_ack     = 1'b0;
            imem_rdata   = $urandom;
            branch       = 1'($urandom);
            jump         = 1'($urandom);
            branch_taken = 1'($urandom);
            @(negedge clk);
        end
        chkb("fetch_req", imem_req, 1'b1);
        chk("fetch_addr", imem_addr, exp_pc);
        chkb("fetch_valid", inst_valid, 1'b0);
        imem_ack   = 1'b1;
        imem_rdata = word;
        @(negedge clk);
        imem_ack = 1'b0;
    endtask

    // Decoder side: check the EXEC window, optionally stall, then apply the
    // final controls and advance the model PC.
    task automatic do_exec(input logic [31:0] word, input logic br, input logic jmp,
                           input logic tk, input int nstall);
        chkb("exec_valid", inst_valid, 1'b1);
        chk("exec_inst", inst, word);
        chk("exec_pc", pc, exp_pc);
        chk("exec_pc_plus4", pc_plus4, exp_pc + 32'd4);
        chkb("exec_req", imem_req, 1'b0);
        chkb("exec_err", fetch_err, 1'b0);
        stall = (nstall > 0);
        for (int s = 0; s < nstall; s++) begin
            branch       = 1'($urandom);
            jump         = 1'($urandom);
            branch_taken = 1'($urandom);
            imem_ack     = 1'($urandom);
            imem_rdata   = $urandom;
            @(negedge clk);
            chk("stall_inst", inst, word);
            chk("stall_pc", pc, exp_pc);
            chkb("stall_valid", inst_valid, 1'b1);
            chkb("stall_req", imem_req, 1'b0);
            if (s == nstall - 1) stall = 1'b0;
        end
        branch       = br;
        jump         = jmp;
        branch_taken = tk;
        imem_ack     = 1'($urandom);
        imem_rdata   = $urandom;
        @(negedge clk);
        imem_ack = 1'b0;
        stall    = 1'b0;
        exp_pc   = ref_next_pc(exp_pc, word, br, jmp, tk);
    endtask

    task automatic txn(input logic [31:0] word, input int delay, input logic br,
                       input logic jmp, input logic tk, input int nstall);
        logic [31:0] from_pc;
        from_pc = exp_pc;
        do_fetch(word, delay);
        do_exec(word, br, jmp, tk, nstall);
        $display("txn pc=%h inst=%h wait=%0d br=%b j=%b tk=%b stall=%0d -> next=%h",
                 from_pc, word, delay, br, jmp, tk, nstall, exp_pc);
    endtask

    initial begin
        rst_n        = 1'b0;
        imem_ack     = 1'b0;
        imem_rdata   = 32'h0;
        branch       = 1'b0;
        jump         = 1'b0;
        branch_taken = 1'b0;
        stall        = 1'b0;
        exp_pc       = RST_PC;

        // Reset state
        @(negedge clk);
        chkb("rst_req", imem_req, 1'b0);
        chkb("rst_valid", inst_valid, 1'b0);
        chk("rst_inst", inst, 32'h0);
        chkb("rst_err", fetch_err, 1'b0);
        chk("rst_pc", pc, RST_PC);
        chk("rst_pc_plus4", pc_plus4, 32'h104);
        chk("rst_addr", imem_addr, RST_PC);

        // One BOOT cycle with idle outputs, then FETCH
        rst_n = 1'b1;
        chkb("boot_req", imem_req, 1'b0);
        @(negedge clk);

        txn(32'h2009_0005, 1, 1'b0, 1'b0, 1'b0, 0);
        chk("first_next_addr", imem_addr, 32'h104);
        txn(32'h0800_0080, 0, 1'b0, 1'b1, 1'b0, 0);
        chk("jump_to_200", imem_addr, 32'h200);
        txn(32'h1000_FFFE, 2, 1'b1, 1'b0, 1'b1, 0);
        chk("branch_taken_addr", imem_addr, 32'h1FC);
        txn(32'h0800_0080, 0, 1'b0, 1'b1, 1'b0, 0);
        txn(32'h1000_FFFE, 1, 1'b1, 1'b0, 1'b0, 0);
        chk("branch_not_taken_addr", imem_addr, 32'h204);
        txn(32'h2009_0005, 0, 1'b0, 1'b0, 1'b0, 3);
        chk("after_stall_addr", imem_addr, 32'h208);
        // Ack in the last permitted cycle must not raise fetch_err
        txn(32'h2409_0001, TMO - 1, 1'b0, 1'b0, 1'b0, 0);
        chkb("late_ack_no_err", fetch_err, 1'b0);
        chk("late_ack_next_addr", imem_addr, 32'h20C);
        // Reach the top of memory via a backward branch from 0, then wrap
        txn(32'h0800_0000, 0, 1'b0, 1'b1, 1'b0, 0);
        txn(32'h1000_FFFE, 0, 1'b1, 1'b0, 1'b1, 0);
        chk("top_addr", imem_addr, 32'hFFFF_FFFC);
        txn(32'h0000_0000, 0, 1'b0, 1'b0, 1'b0, 0);
        chk("wrap_addr", imem_addr, 32'h0000_0000);

        // Randomized traffic against the reference model
        for (int n = 0; n < 40; n++) begin
            txn($urandom, int'($urandom_range(0, TMO - 1)), 1'($urandom), 1'($urandom),
                1'($urandom), int'($urandom_range(0, 2)));
        end

        // Memory never acks: error after TMO request cycles, then sticky
        for (int i = 0; i < TMO; i++) begin
            chkb("tmo_req", imem_req, 1'b1);
            chkb("tmo_err_low", fetch_err, 1'b0);
            imem_ack = 1'b0;
            @(negedge clk);
        end
        chkb("tmo_err", fetch_err, 1'b1);
        chkb("tmo_req_low", imem_req, 1'b0);
        chkb("tmo_valid", inst_valid, 1'b0);
        chk("tmo_inst", inst, 32'h0);
        for (int i = 0; i < 3; i++) begin
            imem_ack   = 1'b1;
            imem_rdata = $urandom;
            @(negedge clk);
            chkb("err_sticky", fetch_err, 1'b1);
            chkb("err_req", imem_req, 1'b0);
        end
        imem_ack = 1'b0;
        $display("txn timeout pc=%h -> ERR", exp_pc);

        // Reset out of ERR, then reset asynchronously in the middle of a fetch
        rst_n = 1'b0;
        #1;
        chkb("err_rst_clear", fetch_err, 1'b0);
        @(negedge clk);
        rst_n  = 1'b1;
        exp_pc = RST_PC;
        @(negedge clk);
        chkb("refetch_req", imem_req, 1'b1);
        chk("refetch_addr", imem_addr, RST_PC);
        @(negedge clk);
        chkb("midfetch_req", imem_req, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chkb("async_rst_req", imem_req, 1'b0);
        chk("async_rst_pc", pc, RST_PC);
        chkb("async_rst_valid", inst_valid, 1'b0);
        $display("txn async reset mid-fetch pc=%h", pc);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Jump with branch also set: jump wins, upper nibble from pc+4
        chk("hi_start_pc", hi_pc, HI_PC);
        do_fetch(32'h0C00_0040, 1);
        chk("hi_exec_inst", hi_inst, 32'h0C00_0040);
        chk("hi_exec_pc_plus4", hi_pc_plus4, 32'h4000_0014);
        do_exec(32'h0C00_0040, 1'b1, 1'b1, 1'($urandom), 0);
        chk("jump_prio_addr", imem_addr, 32'h0000_0100);
        chk("hi_jump_addr", hi_imem_addr, 32'h4000_0100);
        $display("txn jump pc=%h/%h -> next=%h/%h", RST_PC, HI_PC, imem_addr, hi_imem_addr);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
